axi_lite_slave_regs: RTL and testbench
======================================

# axi_lite_slave_regs

AXI4-Lite responder (slave) exposing a bank of 32-bit read/write registers. Sits at the far end of an M00_AXI master port: it accepts write and read transactions, updates or returns register contents, and signals per-transaction OKAY/SLVERR responses. Register contents are also driven out in parallel for use by downstream logic.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width (fixed at 32; WSTRB is 4 bits)
- C_S_AXI_ADDR_WIDTH, 4, byte address width; word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]
- NUM_REGS, 4, implemented registers, 1..2^(C_S_AXI_ADDR_WIDTH-2)

Clock and reset:
- ACLK  in  1  single clock; all logic on rising edge
- ARESETN  in  1  asynchronous, active-low reset

Write address channel:
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write byte address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1
- S_AXI_AWREADY  out  1

Write data channel:
- S_AXI_WDATA  in  32
- S_AXI_WSTRB  in  4  byte lane enables
- S_AXI_WVALID  in  1
- S_AXI_WREADY  out  1

Write response channel:
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID  out  1
- S_AXI_BREADY  in  1

Read address channel:
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1
- S_AXI_ARREADY  out  1

Read data channel:
- S_AXI_RDATA  out  32
- S_AXI_RRESP  out  2
- S_AXI_RVALID  out  1
- S_AXI_RREADY  in  1

Register bank:
- REGS_OUT  out  NUM_REGS*32  register i at bits [32i+31:32i]

## Operation
- Reset (ARESETN=0, asynchronous): all registers 0, REGS_OUT 0, all READY/VALID outputs 0, BRESP/RRESP 00, RDATA 0, held-beat flags cleared. Any in-flight transaction is abandoned.
- All outputs are registered.
- Write path, states WR_IDLE and WR_RESP:
  - WR_IDLE: AWREADY=1 while no address is held; WREADY=1 while no data beat is held. AW and W are accepted independently, in either order or on the same edge.
  - On an AW handshake, capture AWADDR and drop AWREADY. On a W handshake, capture WDATA/WSTRB and drop WREADY.
  - On the edge after both are held: commit the write, set BVALID, and go to WR_RESP.
  - Commit: if index < NUM_REGS, byte lane b of the register is updated iff WSTRB[b]=1, and BRESP=OKAY. Otherwise no register changes and BRESP=SLVERR.
  - WR_RESP: hold BVALID and BRESP until BREADY. On the BVALID&BREADY edge: BVALID←0, clear held flags, AWREADY←1, WREADY←1, go to WR_IDLE.
- Read path, states RD_IDLE and RD_RESP:
  - RD_IDLE: ARREADY=1.
  - On an AR handshake edge: ARREADY←0, RVALID←1, go to RD_RESP. RDATA is latched on that edge from the register value before any write committing on the same edge. Index ≥ NUM_REGS returns RDATA=0 with RRESP=SLVERR.
  - RD_RESP: hold RDATA, RRESP, RVALID until RREADY. On the handshake edge: RVALID←0, ARREADY←1.
- Read and write paths are fully independent and may be active concurrently.
- Address bits [1:0] are ignored.

## Timing
- ARESETN deassertion: AWREADY, WREADY, ARREADY rise at the first ACLK edge with ARESETN=1.
- Write latency: last of AW/W handshakes at edge N → register and REGS_OUT updated, BVALID=1 after edge N+1.
- Read latency: AR handshake at edge N → RVALID=1 and RDATA valid after edge N.
- Response stalls: BVALID/RVALID stay high indefinitely with stable BRESP/RDATA/RRESP while BREADY/RREADY=0; no new transaction is accepted on that path.
- Back-to-back transactions: the B or R handshake at edge M re-raises READY after edge M, giving 1 transaction per 3 cycles (write) and 1 per 2 cycles (read).
- Same-edge read and write to the same register: the read returns the old value; the new value is visible to a read accepted one edge later.
- Reset asserted mid-transaction: outputs go to their reset values immediately, not at the next edge.

## Test plan
- Reset, then AW and W on the same cycle (addr 0x4, data 0xDEADBEEF, strb 0xF) → BVALID one edge later with BRESP=00; REGS_OUT[63:32]=0xDEADBEEF; read of 0x4 returns 0xDEADBEEF, RRESP=00.
- W presented 3 cycles before AW (addr 0x0, data 0x11223344, strb 0x5) with reg0 previously 0xFFFFFFFF → reg0=0xFF22FF44; AWREADY stays 1 while WREADY is 0 during the wait.
- Out-of-range access with NUM_REGS=3: write addr 0xC, data 0x1 → BRESP=10 and no register changes; read 0xC → RDATA=0, RRESP=10.
- BREADY and RREADY held 0 for 10 cycles → BVALID/RVALID and their payloads remain stable; second AW/AR not accepted until the handshake completes.
- Write 0xA5A5A5A5 to reg2 committing on the same edge as an AR handshake to reg2 (old value 0x0) → RDATA=0x0; the following read returns 0xA5A5A5A5.
- ARESETN pulsed low while BVALID=1 → BVALID, AWREADY, WREADY, ARREADY, REGS_OUT all 0 immediately; READYs return 1 after the first edge following release.

Source files
------------

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder for a bank of 32-bit registers. The write and read paths are independent.
// Writes use byte strobes. Unimplemented word indices get SLVERR. All registers are also driven out in parallel.

module axi_lite_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] REGS_OUT
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_RESP = 1'b1} rd_state_t;

  function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else         res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic f_in_range(input logic [IDX_W-1:0] idx);
    return (32'(idx) < 32'(NUM_REGS));
  endfunction

  // Register bank, write path and read path state
  logic [NUM_REGS-1:0][DW-1:0] r_regs;

  wr_state_t        r_wr_state, w_wr_state_nxt;
  logic             r_aw_held, w_aw_held_nxt;
  logic             r_w_held, w_w_held_nxt;
  logic [IDX_W-1:0] r_awidx, w_awidx_nxt;
  logic [DW-1:0]    r_wdata, w_wdata_nxt;
  logic [SW-1:0]    r_wstrb, w_wstrb_nxt;
  logic             r_awready, w_awready_nxt;
  logic             r_wready, w_wready_nxt;
  logic             r_bvalid, w_bvalid_nxt;
  logic [1:0]       r_bresp, w_bresp_nxt;
  logic             w_commit;

  rd_state_t        r_rd_state, w_rd_state_nxt;
  logic             r_arready, w_arready_nxt;
  logic             r_rvalid, w_rvalid_nxt;
  logic [DW-1:0]    r_rdata, w_rdata_nxt;
  logic [1:0]       r_rresp, w_rresp_nxt;

  logic             w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic             w_wr_in_range, w_rd_in_range;
  logic [IDX_W-1:0] w_rd_idx;
  logic [DW-1:0]    w_rd_word;
  logic             w_unused_ok;

  assign w_aw_hs       = S_AXI_AWVALID & r_awready;
  assign w_w_hs        = S_AXI_WVALID & r_wready;
  assign w_b_hs        = r_bvalid & S_AXI_BREADY;
  assign w_ar_hs       = S_AXI_ARVALID & r_arready;
  assign w_r_hs        = r_rvalid & S_AXI_RREADY;
  assign w_wr_in_range = f_in_range(r_awidx);
  assign w_rd_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_rd_in_range = f_in_range(w_rd_idx);

  // Protection bits and byte offsets carry no meaning for a word-wide register bank
  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_wr_state <= WR_IDLE;
    else          r_wr_state <= w_wr_state_nxt;
  end

  // Write FSM next state: commit once both halves are held, then wait for B handshake
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      WR_IDLE: begin
        if (r_aw_held && r_w_held) w_wr_state_nxt = WR_RESP;
        else                       w_wr_state_nxt = WR_IDLE;
      end
      WR_RESP: begin
        if (w_b_hs) w_wr_state_nxt = WR_IDLE;
        else        w_wr_state_nxt = WR_RESP;
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  // Write FSM outputs: next values of the held beat, READYs and the B channel
  always_comb begin
    w_aw_held_nxt = r_aw_held;
    w_w_held_nxt  = r_w_held;
    w_awidx_nxt   = r_awidx;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_commit      = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if (w_aw_hs) begin
          w_aw_held_nxt = 1'b1;
          w_awidx_nxt   = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end else begin
          w_aw_held_nxt = r_aw_held;
          w_awidx_nxt   = r_awidx;
        end
        if (w_w_hs) begin
          w_w_held_nxt = 1'b1;
          w_wdata_nxt  = S_AXI_WDATA;
          w_wstrb_nxt  = S_AXI_WSTRB;
        end else begin
          w_w_held_nxt = r_w_held;
          w_wdata_nxt  = r_wdata;
          w_wstrb_nxt  = r_wstrb;
        end
        if (r_aw_held && r_w_held) begin
          w_commit     = 1'b1;
          w_bvalid_nxt = 1'b1;
          w_bresp_nxt  = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          w_commit     = 1'b0;
          w_bvalid_nxt = 1'b0;
          w_bresp_nxt  = r_bresp;
        end
        // READY also rises here on the first edge after reset, when nothing is held
        w_awready_nxt = ~w_aw_held_nxt;
        w_wready_nxt  = ~w_w_held_nxt;
      end
      WR_RESP: begin
        if (w_b_hs) begin
          w_bvalid_nxt  = 1'b0;
          w_aw_held_nxt = 1'b0;
          w_w_held_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
        end else begin
          w_bvalid_nxt  = r_bvalid;
          w_awready_nxt = 1'b0;
          w_wready_nxt  = 1'b0;
        end
      end
      default: begin
        w_aw_held_nxt = 1'b0;
        w_w_held_nxt  = 1'b0;
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b0;
        w_bvalid_nxt  = 1'b0;
        w_bresp_nxt   = RESP_OKAY;
      end
    endcase
  end

  // Write path registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awidx   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_awidx   <= w_awidx_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // Register bank: an out-of-range index matches no entry, so nothing changes
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit && (r_awidx == IDX_W'(i))) r_regs[i] <= f_merge(r_regs[i], r_wdata, r_wstrb);
        else                                    r_regs[i] <= r_regs[i];
      end
    end
  end

  // Read mux sees the pre-commit bank, so a same-edge read returns the old value
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_idx == IDX_W'(i)) w_rd_word = r_regs[i];
      else                       w_rd_word = w_rd_word;
    end
  end

  // Read FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_rd_state <= RD_IDLE;
    else          r_rd_state <= w_rd_state_nxt;
  end

  // Read FSM next state
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE: begin
        if (w_ar_hs) w_rd_state_nxt = RD_RESP;
        else         w_rd_state_nxt = RD_IDLE;
      end
      RD_RESP: begin
        if (w_r_hs) w_rd_state_nxt = RD_IDLE;
        else        w_rd_state_nxt = RD_RESP;
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM outputs: next values of ARREADY and the R channel
  always_comb begin
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    case (r_rd_state)
      RD_IDLE: begin
        if (w_ar_hs) begin
          w_arready_nxt = 1'b0;
          w_rvalid_nxt  = 1'b1;
          w_rdata_nxt   = w_rd_in_range ? w_rd_word : '0;
          w_rresp_nxt   = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          w_arready_nxt = 1'b1;
          w_rvalid_nxt  = 1'b0;
        end
      end
      RD_RESP: begin
        if (w_r_hs) begin
          w_arready_nxt = 1'b1;
          w_rvalid_nxt  = 1'b0;
        end else begin
          w_arready_nxt = 1'b0;
          w_rvalid_nxt  = r_rvalid;
        end
      end
      default: begin
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = 1'b0;
        w_rdata_nxt   = '0;
        w_rresp_nxt   = RESP_OKAY;
      end
    endcase
  end

  // Read path registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign REGS_OUT      = r_regs;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Randomized AXI4-Lite bench for axi_lite_slave_regs (NUM_REGS=3, so index 3 is unimplemented),
// checked against an array-based register model.

module tb_axi_lite_slave_regs;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 3;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [3:0]      S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;
  logic [NR*DW-1:0] REGS_OUT;

  axi_lite_slave_regs #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_REGS(NR)
  ) u_dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .REGS_OUT(REGS_OUT)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] m_regs [NR];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = m_regs[i];
    return r;
  endfunction

  function automatic bit m_in_range(input logic [AW-1:0] a);
    return (int'(a[AW-1:2]) < NR);
  endfunction

  task automatic m_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                         output logic [1:0] resp);
    int idx;
    idx = int'(a[AW-1:2]);
    if (m_in_range(a)) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic m_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
    if (m_in_range(a)) begin
      d    = m_regs[int'(a[AW-1:2])];
      resp = 2'b00;
    end else begin
      d    = '0;
      resp = 2'b10;
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // AW after aw_dly cycles, W after w_dly cycles, B held off for bstall cycles
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int bstall);
    bit aw_done, w_done, aw_rdy, w_rdy;
    int cyc;
    logic [1:0] exp_resp;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      S_AXI_AWADDR  = addr;
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      aw_rdy = S_AXI_AWREADY;
      w_rdy  = S_AXI_WREADY;
      if (w_done && !aw_done) begin
        check_eq("awready_while_w_held", S_AXI_AWREADY, 1'b1);
        check_eq("wready_while_w_held", S_AXI_WREADY, 1'b0);
      end
      tick();
      cyc++;
      if (S_AXI_AWVALID && aw_rdy) aw_done = 1'b1;
      if (S_AXI_WVALID && w_rdy)   w_done  = 1'b1;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check_eq("wr_handshakes", {aw_done, w_done}, 2'b11);
    check_eq("bvalid_not_early", S_AXI_BVALID, 1'b0);
    m_write(addr, data, strb, exp_resp);
    tick();
    check_eq("bvalid", S_AXI_BVALID, 1'b1);
    check_eq("bresp", S_AXI_BRESP, exp_resp);
    check_eq("regs_out_after_wr", REGS_OUT, m_flat());
    for (int s = 0; s < bstall; s++) begin
      S_AXI_AWVALID = 1'b1;
      S_AXI_AWADDR  = 4'($urandom_range(0, 15));
      check_eq("awready_during_bstall", S_AXI_AWREADY, 1'b0);
      tick();
      check_eq("bvalid_stall", S_AXI_BVALID, 1'b1);
      check_eq("bresp_stall", S_AXI_BRESP, exp_resp);
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_BREADY  = 1'b1;
    tick();
    S_AXI_BREADY  = 1'b0;
    check_eq("bvalid_drop", S_AXI_BVALID, 1'b0);
    check_eq("awready_back", S_AXI_AWREADY, 1'b1);
    check_eq("wready_back", S_AXI_WREADY, 1'b1);
    check_eq("regs_out_stable", REGS_OUT, m_flat());
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int ar_dly, input int rstall);
    bit done, rdy;
    int cyc;
    logic [DW-1:0] exp_d;
    logic [1:0] exp_resp;
    done = 1'b0; cyc = 0;
    m_read(addr, exp_d, exp_resp);
    while (!done && cyc < 40) begin
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = (cyc >= ar_dly);
      rdy = S_AXI_ARREADY;
      tick();
      cyc++;
      if (S_AXI_ARVALID && rdy) done = 1'b1;
    end
    S_AXI_ARVALID = 1'b0;
    check_eq("ar_handshake", done, 1'b1);
    check_eq("rvalid", S_AXI_RVALID, 1'b1);
    check_eq("rdata", S_AXI_RDATA, exp_d);
    check_eq("rresp", S_AXI_RRESP, exp_resp);
    for (int s = 0; s < rstall; s++) begin
      S_AXI_ARVALID = 1'b1;
      S_AXI_ARADDR  = 4'($urandom_range(0, 15));
      check_eq("arready_during_rstall", S_AXI_ARREADY, 1'b0);
      tick();
      check_eq("rvalid_stall", S_AXI_RVALID, 1'b1);
      check_eq("rdata_stall", S_AXI_RDATA, exp_d);
      check_eq("rresp_stall", S_AXI_RRESP, exp_resp);
    end
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b1;
    tick();
    S_AXI_RREADY  = 1'b0;
    check_eq("rvalid_drop", S_AXI_RVALID, 1'b0);
    check_eq("arready_back", S_AXI_ARREADY, 1'b1);
  endtask

  initial begin
    logic [1:0] resp;
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'b000; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b000; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;

    // Reset state
    repeat (2) @(posedge ACLK);
    #2;
    check_eq("rst_awready", S_AXI_AWREADY, 1'b0);
    check_eq("rst_wready", S_AXI_WREADY, 1'b0);
    check_eq("rst_arready", S_AXI_ARREADY, 1'b0);
    check_eq("rst_bvalid", S_AXI_BVALID, 1'b0);
    check_eq("rst_rvalid", S_AXI_RVALID, 1'b0);
    check_eq("rst_bresp", S_AXI_BRESP, 2'b00);
    check_eq("rst_rresp", S_AXI_RRESP, 2'b00);
    check_eq("rst_rdata", S_AXI_RDATA, 32'h0);
    check_eq("rst_regs_out", REGS_OUT, 96'h0);
    ARESETN = 1'b1;
    #1;
    check_eq("awready_before_edge", S_AXI_AWREADY, 1'b0);
    tick();
    check_eq("awready_after_rst", S_AXI_AWREADY, 1'b1);
    check_eq("wready_after_rst", S_AXI_WREADY, 1'b1);
    check_eq("arready_after_rst", S_AXI_ARREADY, 1'b1);

    // AW and W together, then read back
    axi_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check_eq("reg1_deadbeef", REGS_OUT[63:32], 32'hDEADBEEF);
    axi_read(4'h4, 0, 0);

    // W three cycles ahead of AW, partial strobes
    axi_write(4'h0, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'h11223344, 4'h5, 3, 0, 0);
    check_eq("reg0_strobe_merge", REGS_OUT[31:0], 32'hFF22FF44);

    // Unimplemented index
    axi_write(4'hC, 32'h00000001, 4'hF, 0, 0, 0);
    check_eq("oor_regs_unchanged", REGS_OUT, m_flat());
    axi_read(4'hC, 0, 0);

    // Long response stalls
    axi_write(4'h8, 32'h0BADF00D, 4'hF, 0, 1, 10);
    axi_read(4'h8, 0, 10);
    axi_write(4'h8, 32'h00000000, 4'hF, 0, 0, 0);

    // Write commit and AR handshake on the same edge
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check_eq("same_edge_bvalid_pre", S_AXI_BVALID, 1'b0);
    S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1;
    check_eq("same_edge_arready", S_AXI_ARREADY, 1'b1);
    tick();
    S_AXI_ARVALID = 1'b0;
    check_eq("same_edge_rvalid", S_AXI_RVALID, 1'b1);
    check_eq("same_edge_rdata_old", S_AXI_RDATA, m_regs[2]);
    check_eq("same_edge_bvalid", S_AXI_BVALID, 1'b1);
    m_write(4'h8, 32'hA5A5A5A5, 4'hF, resp);
    check_eq("same_edge_bresp", S_AXI_BRESP, resp);
    check_eq("same_edge_reg2", REGS_OUT[95:64], 32'hA5A5A5A5);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    check_eq("same_edge_bvalid_drop", S_AXI_BVALID, 1'b0);
    check_eq("same_edge_rvalid_drop", S_AXI_RVALID, 1'b0);
    axi_read(4'h8, 0, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset pulse while a write response is pending
    axi_write(4'h4, 32'h12345678, 4'hF, 0, 0, 0);
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tick();
    check_eq("pre_rst_bvalid", S_AXI_BVALID, 1'b1);
    ARESETN = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    check_eq("midrst_bvalid", S_AXI_BVALID, 1'b0);
    check_eq("midrst_awready", S_AXI_AWREADY, 1'b0);
    check_eq("midrst_wready", S_AXI_WREADY, 1'b0);
    check_eq("midrst_arready", S_AXI_ARREADY, 1'b0);
    check_eq("midrst_regs_out", REGS_OUT, m_flat());
    #1;
    ARESETN = 1'b1;
    #1;
    check_eq("rel_awready_before_edge", S_AXI_AWREADY, 1'b0);
    tick();
    check_eq("rel_awready", S_AXI_AWREADY, 1'b1);
    check_eq("rel_wready", S_AXI_WREADY, 1'b1);
    check_eq("rel_arready", S_AXI_ARREADY, 1'b1);
    check_eq("rel_bvalid", S_AXI_BVALID, 1'b0);
    axi_read(4'h4, 0, 0);
    axi_write(4'h4, 32'h5A5A0000, 4'hC, 1, 0, 0);
    axi_read(4'h4, 1, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
